// File: rtl/path_player.sv
`default_nettype none
// ============================================================================
// Module      : path_player
// Description : Solved-path playback responder. On a read_start request it
//               replays the walk from the start cell, draining one direction
//               per move from a first-word-fall-through queue and presenting
//               each visited cell on a valid/ready port, held for at least
//               STEP_CYCLES cycles. Pulses read_path_finished when the queue
//               runs dry, then waits for read_start to fall before re-arming.
// Ports       : clk, rst (async, active-high)
//               read_start          - show-phase level request
//               queue_empty/dout    - FWFT path queue head (2-bit direction)
//               dequeue             - pop queue head at this edge
//               out_x/out_y         - current cell
//               out_valid/out_ready - cell handshake
//               step_count          - moves replayed (saturating)
//               wrap_err            - sticky coordinate wrap flag
//               read_path_finished  - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module path_player #(
    parameter int X_W         = 4,
    parameter int Y_W         = 4,
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_start,
    input  logic             queue_empty,
    input  logic [1:0]       queue_dout,
    output logic             dequeue,
    output logic [X_W-1:0]   out_x,
    output logic [Y_W-1:0]   out_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] step_count,
    output logic             wrap_err,
    output logic             read_path_finished
);

    localparam logic [X_W-1:0]   START_XV = X_W'(START_X);
    localparam logic [Y_W-1:0]   START_YV = Y_W'(START_Y);
    localparam logic [X_W-1:0]   X_MAX    = '1;
    localparam logic [Y_W-1:0]   Y_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Hold counter counts 0 .. STEP_CYCLES-2 while in HOLD. Sized to at
    // least one bit so the logic stays legal when HOLD is unreachable.
    localparam int              HOLD_W      = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam int              HOLD_LAST_I = (STEP_CYCLES > 2) ? (STEP_CYCLES - 2) : 0;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_LAST_I[HOLD_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EMIT    = 3'd1,
        S_HOLD    = 3'd2,
        S_FETCH   = 3'd3,
        S_FINISH  = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              load_start;
    logic              hold_done;
    logic [HOLD_W-1:0] hold_cnt;
    logic [X_W-1:0]    x_nxt;
    logic [Y_W-1:0]    y_nxt;
    logic              wrap_nxt;

    assign hold_done = (hold_cnt == HOLD_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt          = state;
        load_start         = 1'b0;
        dequeue            = 1'b0;
        out_valid          = 1'b0;
        read_path_finished = 1'b0;
        case (state)
            S_IDLE: begin
                if (read_start) begin
                    load_start = 1'b1;
                    state_nxt  = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (!read_start) begin
                    state_nxt = S_IDLE;
                end else if (out_ready) begin
                    state_nxt = (STEP_CYCLES > 1) ? S_HOLD : S_FETCH;
                end
            end
            S_HOLD: begin
                if (!read_start) begin
                    state_nxt = S_IDLE;
                end else if (hold_done) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                // The pop is gated by read_start so an abort in FETCH never
                // consumes a queue entry.
                if (!read_start) begin
                    state_nxt = S_IDLE;
                end else if (queue_empty) begin
                    state_nxt = S_FINISH;
                end else begin
                    dequeue   = 1'b1;
                    state_nxt = S_EMIT;
                end
            end
            S_FINISH: begin
                read_path_finished = 1'b1;
                state_nxt          = S_RELEASE;
            end
            S_RELEASE: begin
                if (!read_start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next cell from the head direction; wrap flags a modulo rollover
    // ------------------------------------------------------------------
    always_comb begin
        x_nxt    = out_x;
        y_nxt    = out_y;
        wrap_nxt = 1'b0;
        case (queue_dout)
            2'b00: begin
                x_nxt    = out_x + X_W'(1);
                wrap_nxt = (out_x == X_MAX);
            end
            2'b01: begin
                y_nxt    = out_y - Y_W'(1);
                wrap_nxt = (out_y == '0);
            end
            2'b10: begin
                x_nxt    = out_x - X_W'(1);
                wrap_nxt = (out_x == '0);
            end
            default: begin
                y_nxt    = out_y + Y_W'(1);
                wrap_nxt = (out_y == Y_MAX);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hold counter: free-cleared outside HOLD so every HOLD entry starts at 0
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == S_HOLD) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Cell position, move counter and sticky wrap flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_x      <= START_XV;
            out_y      <= START_YV;
            step_count <= '0;
            wrap_err   <= 1'b0;
        end else if (load_start) begin
            out_x      <= START_XV;
            out_y      <= START_YV;
            step_count <= '0;
            wrap_err   <= 1'b0;
        end else if (dequeue) begin
            out_x    <= x_nxt;
            out_y    <= y_nxt;
            wrap_err <= wrap_err | wrap_nxt;
            if (step_count != CNT_MAX) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_path_player.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_path_player
// Description : Directed bench for path_player. dut1 uses STEP_CYCLES=1 and
//               start (0,0); dut3 uses STEP_CYCLES=3 and start (5,7). Each
//               DUT reads from a FWFT queue model. Expected cells for dut1
//               are queued when stimulus is loaded and popped on every
//               accepted handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_path_player;

    logic       clk;
    logic       rst;

    logic       rs1, qe1, deq1, v1, rdy1, wr1, fin1;
    logic [1:0] qd1;
    logic [3:0] x1, y1;
    logic [7:0] sc1;

    logic       rs3, qe3, deq3, v3, rdy3, wr3, fin3;
    logic [1:0] qd3;
    logic [3:0] x3, y3;
    logic [7:0] sc3;

    logic [1:0] q1[$];
    logic [1:0] q3[$];
    logic       pend1, pend3;
    logic [7:0] exp_q[$];
    logic [7:0] exp_cell;

    int cmps = 0;
    int errs = 0;

    path_player #(.X_W(4), .Y_W(4), .START_X(0), .START_Y(0),
                  .STEP_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .read_start(rs1), .queue_empty(qe1),
        .queue_dout(qd1), .dequeue(deq1), .out_x(x1), .out_y(y1),
        .out_valid(v1), .out_ready(rdy1), .step_count(sc1),
        .wrap_err(wr1), .read_path_finished(fin1)
    );

    path_player #(.X_W(4), .Y_W(4), .START_X(5), .START_Y(7),
                  .STEP_CYCLES(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .read_start(rs3), .queue_empty(qe3),
        .queue_dout(qd3), .dequeue(deq3), .out_x(x3), .out_y(y3),
        .out_valid(v3), .out_ready(rdy3), .step_count(sc3),
        .wrap_err(wr3), .read_path_finished(fin3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        cmps++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Queue models: pop one cycle-stable dequeue request just after the edge
    always @(negedge clk) begin
        pend1 = deq1;
        pend3 = deq3;
    end

    always @(posedge clk) begin
        #1;
        if (pend1 && q1.size() > 0) void'(q1.pop_front());
        if (pend3 && q3.size() > 0) void'(q3.pop_front());
        qe1 = (q1.size() == 0);
        qd1 = (q1.size() > 0) ? q1[0] : 2'b00;
        qe3 = (q3.size() == 0);
        qd3 = (q3.size() > 0) ? q3[0] : 2'b00;
    end

    // Protocol checks and cell scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            chk("deq_on_empty1", {31'b0, deq1 & qe1}, 32'd0);
            chk("deq_on_empty3", {31'b0, deq3 & qe3}, 32'd0);
            if (v1 && rdy1) begin
                chk("cell_pending", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_cell = exp_q.pop_front();
                    chk("cell", {24'b0, x1, y1}, {24'b0, exp_cell});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rs1 = 1'b0; rs3 = 1'b0; rdy1 = 1'b1; rdy3 = 1'b1;
        qe1 = 1'b1; qe3 = 1'b1; qd1 = 2'b00; qd3 = 2'b00; pend1 = 1'b0; pend3 = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_x1", x1, 0);   chk("rst_y1", y1, 0);
        chk("rst_v1", v1, 0);   chk("rst_deq1", deq1, 0);
        chk("rst_fin1", fin1, 0); chk("rst_sc1", sc1, 0);
        chk("rst_wr1", wr1, 0);
        chk("rst_x3", x3, 5);   chk("rst_y3", y3, 7);
        rst = 1'b0;
        tick();

        // Empty queue: EMIT T1, FETCH T2, finish T3
        exp_q.push_back(8'h00);
        rs1 = 1'b1;
        tick();
        chk("e_v_t1", v1, 1); chk("e_x_t1", x1, 0); chk("e_y_t1", y1, 0);
        tick();
        chk("e_v_t2", v1, 0); chk("e_deq_t2", deq1, 0); chk("e_fin_t2", fin1, 0);
        tick();
        chk("e_fin_t3", fin1, 1); chk("e_sc", sc1, 0);
        tick();
        chk("e_fin_t4", fin1, 0);
        rs1 = 1'b0;
        tick();

        // Queue [00,00,11], full-rate walk
        q1 = '{2'b00, 2'b00, 2'b11};
        exp_q.push_back(8'h00); exp_q.push_back(8'h10);
        exp_q.push_back(8'h20); exp_q.push_back(8'h21);
        tick();
        rs1 = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("w_deq_t%0d", k), deq1, (k == 2 || k == 4 || k == 6) ? 1 : 0);
            chk($sformatf("w_v_t%0d", k), v1, ((k % 2) == 1 && k <= 7) ? 1 : 0);
            chk($sformatf("w_fin_t%0d", k), fin1, (k == 9) ? 1 : 0);
            if (k < 9) tick();
        end
        chk("w_sc", sc1, 3); chk("w_wr", wr1, 0);
        // read_start held after finish: no second pulse, no replay
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("held_fin", fin1, 0); chk("held_v", v1, 0);
        end
        rs1 = 1'b0;
        tick();
        // Rising again replays; dropping it in EMIT aborts to IDLE
        exp_q.push_back(8'h00);
        rs1 = 1'b1;
        tick();
        chk("replay_v", v1, 1);
        rs1 = 1'b0;
        tick();
        chk("abort_emit_v", v1, 0); chk("abort_emit_deq", deq1, 0);
        tick();

        // Backpressure: ready low for 4 cycles during (0,0)
        q1 = '{2'b00};
        exp_q.push_back(8'h00); exp_q.push_back(8'h10);
        rdy1 = 1'b0;
        tick();
        rs1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("bp_v", v1, 1); chk("bp_x", x1, 0); chk("bp_deq", deq1, 0);
        end
        rdy1 = 1'b1;
        tick();
        chk("bp_deq_t6", deq1, 1);
        tick();
        chk("bp_v_t7", v1, 1); chk("bp_x_t7", x1, 1);
        tick();
        chk("bp_deq_t8", deq1, 0);
        tick();
        chk("bp_fin_t9", fin1, 1); chk("bp_sc", sc1, 1);
        rs1 = 1'b0;
        tick();

        // Wrap: [10,01] from (0,0)
        q1 = '{2'b10, 2'b01};
        exp_q.push_back(8'h00); exp_q.push_back(8'hF0); exp_q.push_back(8'hFF);
        tick();
        rs1 = 1'b1;
        tick();
        chk("wr_t1", wr1, 0);
        tick(); tick();
        chk("wr_x_t3", x1, 15); chk("wr_t3", wr1, 1);
        tick(); tick();
        chk("wr_y_t5", y1, 15); chk("wr_t5", wr1, 1);
        tick(); tick();
        chk("wr_fin_t7", fin1, 1);
        rs1 = 1'b0;
        tick(); tick();
        chk("wr_sticky_idle", wr1, 1);

        // STEP_CYCLES=3, queue [11] from (5,7)
        q3 = '{2'b11};
        tick();
        rs3 = 1'b1;
        tick();
        chk("s3_v_t1", v3, 1); chk("s3_x_t1", x3, 5); chk("s3_y_t1", y3, 7);
        tick();
        chk("s3_hold_v_t2", v3, 0); chk("s3_hold_deq_t2", deq3, 0);
        tick();
        chk("s3_hold_v_t3", v3, 0); chk("s3_hold_deq_t3", deq3, 0);
        tick();
        chk("s3_deq_t4", deq3, 1);
        tick();
        chk("s3_v_t5", v3, 1); chk("s3_y_t5", y3, 8); chk("s3_sc_t5", sc3, 1);
        tick(); tick(); tick();
        chk("s3_deq_t8", deq3, 0); chk("s3_fin_t8", fin3, 0);
        tick();
        chk("s3_fin_t9", fin3, 1);
        rs3 = 1'b0;
        tick();

        // Abort in HOLD: no finish, queue untouched
        q3 = '{2'b00, 2'b00};
        tick();
        rs3 = 1'b1;
        tick();
        chk("ab_v_t1", v3, 1);
        tick();
        chk("ab_hold_v", v3, 0);
        rs3 = 1'b0;
        tick();
        chk("ab_fin_t3", fin3, 0); chk("ab_deq_t3", deq3, 0); chk("ab_v_t3", v3, 0);
        tick();
        chk("ab_fin_t4", fin3, 0); chk("ab_qsize", q3.size(), 2);
        chk("ab_x", x3, 5); chk("ab_y", y3, 7); chk("ab_sc", sc3, 0);
        q3.delete();
        tick();

        // New start clears wrap_err; async reset mid-EMIT
        q1 = '{2'b10, 2'b00};
        exp_q.push_back(8'h00);
        tick();
        rs1 = 1'b1;
        tick();
        chk("rs_wr_clear", wr1, 0); chk("rs_v_t1", v1, 1);
        tick();
        chk("rs_deq_t2", deq1, 1);
        rdy1 = 1'b0;
        tick();
        chk("rs_x_t3", x1, 15); chk("rs_wr_t3", wr1, 1); chk("rs_sc_t3", sc1, 1);
        chk("rs_v_t3", v1, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_x", x1, 0);   chk("arst_y", y1, 0);
        chk("arst_v", v1, 0);   chk("arst_deq", deq1, 0);
        chk("arst_fin", fin1, 0); chk("arst_sc", sc1, 0);
        chk("arst_wr", wr1, 0); chk("arst_qsize", q1.size(), 1);
        tick();
        rst = 1'b0; rs1 = 1'b0; rdy1 = 1'b1;
        q1.delete();
        tick(); tick();
        chk("post_rst_v", v1, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
`default_nettype wire
